// File: rtl/ula_seq.sv
// ula_seq -- multi-cycle WIDTH-bit ULA with a start/busy/done handshake.
//
// Ten operations (NOT, AND, OR, XOR, ADD, SUB, SLR, SRR, MUL, ROL). Operands
// and select are captured when a request is accepted. The result and flags
// are registered at completion and held until the next completion or reset.
// Shifts, rotate and MUL move one bit position per EXEC cycle.
//
// Build option:
//   ULA_SEQ_FAST_MUL_EN  MUL becomes a single-cycle combinational multiply.
//                        When undefined, MUL is an iterative shift-add with
//                        latency WIDTH.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   start     request, taken when the block is free
//   select    opcode (SEL_W bits)
//   a, b      operands (WIDTH bits)
//   s         registered result
//   busy      operation in progress
//   done      one-cycle pulse, s and flags valid
//   zero      s == 0
//   negative  s[WIDTH-1]
//   carry     carry / borrow / shift-out / MUL overflow
//   err       last select was invalid
module ula_seq #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SEL_W-1:0] select,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             busy,
  output logic             done,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_V     = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    LAT_MUL = CW'(WIDTH - 1);

  localparam logic [SEL_W-1:0] OP_NOT = SEL_W'(0);
  localparam logic [SEL_W-1:0] OP_AND = SEL_W'(1);
  localparam logic [SEL_W-1:0] OP_OR  = SEL_W'(2);
  localparam logic [SEL_W-1:0] OP_XOR = SEL_W'(3);
  localparam logic [SEL_W-1:0] OP_ADD = SEL_W'(4);
  localparam logic [SEL_W-1:0] OP_SUB = SEL_W'(5);
  localparam logic [SEL_W-1:0] OP_SLR = SEL_W'(6);
  localparam logic [SEL_W-1:0] OP_SRR = SEL_W'(7);
  localparam logic [SEL_W-1:0] OP_MUL = SEL_W'(8);
  localparam logic [SEL_W-1:0] OP_ROL = SEL_W'(9);

  typedef enum logic {IDLE, EXEC} state_t;
  state_t state_q, state_d;

  logic             accept, finish;
  logic [SEL_W-1:0] op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [CW-1:0]    cnt_q;
  logic             step_q;       // op advances one bit every EXEC cycle
  logic [WIDTH-1:0] w_q, w_nx;    // shift/rotate value, or MUL multiplier
  logic             cry_q, cry_nx;
  logic [2*WIDTH-1:0] acc_q, acc_nx, mc_q, mc_nx;

  // Accept-time decode. These are exactly the values being latched, so the
  // latency and b >= WIDTH test are decided on the captured operands.
  logic             big;
  logic [CW-1:0]    rot, lat_m1;
  logic             step_en;
  logic [WIDTH-1:0] w_init;

  always_comb begin
    big     = (b >= W_V);
    rot     = b[CW-1:0];
    lat_m1  = '0;
    step_en = 1'b0;
    w_init  = a;
    case (select)
      OP_SLR, OP_SRR: begin
        if (big) w_init = '0;
        else if (b != '0) begin
          lat_m1  = CW'(b - WIDTH'(1));
          step_en = 1'b1;
        end
      end
      OP_ROL: begin
        if (rot != '0) begin
          lat_m1  = rot - CW'(1);
          step_en = 1'b1;
        end
      end
      OP_MUL: begin
`ifndef ULA_SEQ_FAST_MUL_EN
        lat_m1  = LAT_MUL;
        step_en = 1'b1;
        w_init  = b;
`endif
      end
      default: ;
    endcase
  end

  // FSM. The final EXEC cycle may take the next request directly, which lets
  // single-cycle ops stream one result per clock with start held high.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_d = EXEC;
      end
      EXEC: if (cnt_q == '0) begin
        finish = 1'b1;
        if (start) begin
          accept  = 1'b1;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  assign busy = (state_q == EXEC);

  // One bit-step of the iterative ops.
  always_comb begin
    w_nx   = w_q;
    cry_nx = cry_q;
    acc_nx = acc_q;
    mc_nx  = mc_q;
    if (step_q) begin
      case (op_q)
        OP_SLR: begin
          cry_nx = w_q[WIDTH-1];
          w_nx   = {w_q[WIDTH-2:0], 1'b0};
        end
        OP_SRR: begin
          cry_nx = w_q[0];
          w_nx   = {1'b0, w_q[WIDTH-1:1]};
        end
        OP_ROL: w_nx = {w_q[WIDTH-2:0], w_q[WIDTH-1]};
        OP_MUL: begin
          acc_nx = acc_q + (w_q[0] ? mc_q : '0);
          mc_nx  = {mc_q[2*WIDTH-2:0], 1'b0};
          w_nx   = {1'b0, w_q[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end

`ifdef ULA_SEQ_FAST_MUL_EN
  logic [2*WIDTH-1:0] prod;
  assign prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
`endif

  // Result at completion; iterative ops include their final step here.
  logic [WIDTH-1:0] res;
  logic             res_c, res_err;

  always_comb begin
    res     = '0;
    res_c   = 1'b0;
    res_err = 1'b0;
    case (op_q)
      OP_NOT: res = ~b_q;
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_ADD: {res_c, res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB: begin
        res   = a_q - b_q;
        res_c = (a_q < b_q);
      end
      OP_SLR, OP_SRR: begin
        res   = w_nx;
        res_c = cry_nx;
      end
      OP_ROL: res = w_nx;
      OP_MUL: begin
`ifdef ULA_SEQ_FAST_MUL_EN
        res   = prod[WIDTH-1:0];
        res_c = |prod[2*WIDTH-1:WIDTH];
`else
        res   = acc_nx[WIDTH-1:0];
        res_c = |acc_nx[2*WIDTH-1:WIDTH];
`endif
      end
      default: res_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s        <= '0;
      done     <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      carry    <= 1'b0;
      err      <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      step_q   <= 1'b0;
      w_q      <= '0;
      cry_q    <= 1'b0;
      acc_q    <= '0;
      mc_q     <= '0;
    end else begin
      done <= finish;
      if (finish) begin
        s        <= res;
        zero     <= (res == '0);
        negative <= res[WIDTH-1];
        carry    <= res_c;
        err      <= res_err;
      end
      if (accept) begin
        op_q   <= select;
        a_q    <= a;
        b_q    <= b;
        cnt_q  <= lat_m1;
        step_q <= step_en;
        w_q    <= w_init;
        cry_q  <= 1'b0;
        acc_q  <= '0;
        mc_q   <= {{WIDTH{1'b0}}, a};
      end else if (state_q == EXEC) begin
        cnt_q <= cnt_q - CW'(1);
        w_q   <= w_nx;
        cry_q <= cry_nx;
        acc_q <= acc_nx;
        mc_q  <= mc_nx;
      end
    end
  end

endmodule

// File: tb/tb_ula_seq.sv
// Directed bench for ula_seq at WIDTH=8: opcode sweep, flag corner cases,
// start-while-busy, streaming, abort by reset and invalid opcodes.
module tb_ula_seq;

  logic       clk = 1'b0;
  logic       rst_n, start;
  logic [3:0] select;
  logic [7:0] a, b, s;
  logic       busy, done, zero, negative, carry, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ula_seq #(.WIDTH(8), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .select(select),
    .a(a), .b(b), .s(s), .busy(busy), .done(done), .zero(zero),
    .negative(negative), .carry(carry), .err(err)
  );

`ifdef ULA_SEQ_FAST_MUL_EN
  localparam int MUL_L = 1;
  // long op for the busy tests: SLR 0x47 by 7
  localparam logic [3:0] LONG_SEL = 4'd6;
  localparam logic [7:0] LONG_B   = 8'h07;
  localparam logic [7:0] LONG_S   = 8'h80;
  localparam int         LONG_L   = 7;
  localparam logic       LONG_C   = 1'b1;
`else
  localparam int MUL_L = 8;
  // long op for the busy tests: MUL 0x47 * 2
  localparam logic [3:0] LONG_SEL = 4'd8;
  localparam logic [7:0] LONG_B   = 8'h02;
  localparam logic [7:0] LONG_S   = 8'h8E;
  localparam int         LONG_L   = 8;
  localparam logic       LONG_C   = 1'b0;
`endif

  localparam logic [7:0] SW_S [10] = '{8'hFD, 8'h02, 8'h47, 8'h45, 8'h49,
                                       8'h45, 8'h1C, 8'h11, 8'h8E, 8'h1D};
  localparam int         SW_L [10] = '{1, 1, 1, 1, 1, 1, 2, 2, MUL_L, 2};
  localparam logic       SW_C [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0};

  // Issue one request and count edges until done; lat = -1 on timeout.
  task automatic run_op(input logic [3:0] sel, input logic [7:0] oa,
                        input logic [7:0] ob, output int lat);
    @(negedge clk);
    select = sel; a = oa; b = ob; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; select = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s, busy, done, zero, negative, carry, err} !== 14'h0) begin
      errors++;
      $display("FAIL reset: got s=%h busy=%b done=%b z=%b n=%b c=%b e=%b, want all 0",
               s, busy, done, zero, negative, carry, err);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    int lat;
    logic [3:0] ef;
    for (int i = 0; i < 10; i++) begin
      run_op(4'(i), 8'h47, 8'h02, lat);
      ef = {SW_S[i] == 8'h00, SW_S[i][7], SW_C[i], 1'b0};
      checks++;
      if (lat !== SW_L[i]) begin
        errors++;
        $display("FAIL sweep_lat op%0d: got %0d want %0d", i, lat, SW_L[i]);
      end
      checks++;
      if (s !== SW_S[i]) begin
        errors++;
        $display("FAIL sweep_s op%0d: got %h want %h", i, s, SW_S[i]);
      end
      checks++;
      if ({zero, negative, carry, err} !== ef) begin
        errors++;
        $display("FAIL sweep_flags op%0d: got zncE=%b want %b", i,
                 {zero, negative, carry, err}, ef);
      end
    end
  endtask

  task automatic test_sub();
    int lat;
    run_op(4'd5, 8'h47, 8'h47, lat);
    checks++;
    if ({s, zero, negative, carry} !== {8'h00, 3'b100}) begin
      errors++;
      $display("FAIL sub_eq: got s=%h znc=%b%b%b want 00 100", s, zero, negative, carry);
    end
    run_op(4'd5, 8'h02, 8'h03, lat);
    checks++;
    if ({s, zero, negative, carry} !== {8'hFF, 3'b011}) begin
      errors++;
      $display("FAIL sub_borrow: got s=%h znc=%b%b%b want ff 011", s, zero, negative, carry);
    end
  endtask

  task automatic test_shift_edges();
    int lat;
    run_op(4'd9, 8'h47, 8'h0C, lat);  // rotate by 12 mod 8 = 4
    checks++;
    if (lat !== 4 || s !== 8'h74 || carry !== 1'b0) begin
      errors++;
      $display("FAIL rol_mod: got L=%0d s=%h c=%b want L=4 s=74 c=0", lat, s, carry);
    end
    run_op(4'd6, 8'h47, 8'h09, lat);  // shift count >= WIDTH
    checks++;
    if (lat !== 1 || s !== 8'h00 || zero !== 1'b1 || carry !== 1'b0) begin
      errors++;
      $display("FAIL slr_big: got L=%0d s=%h z=%b c=%b want L=1 s=00 z=1 c=0",
               lat, s, zero, carry);
    end
    run_op(4'd7, 8'h47, 8'h00, lat);  // shift by zero
    checks++;
    if (lat !== 1 || s !== 8'h47 || carry !== 1'b0) begin
      errors++;
      $display("FAIL srr_zero: got L=%0d s=%h c=%b want L=1 s=47 c=0", lat, s, carry);
    end
    run_op(4'd7, 8'h47, 8'h01, lat);
    checks++;
    if (lat !== 1 || s !== 8'h23 || carry !== 1'b1) begin
      errors++;
      $display("FAIL srr_one: got L=%0d s=%h c=%b want L=1 s=23 c=1", lat, s, carry);
    end
    run_op(4'd9, 8'h47, 8'h08, lat);  // rotate by WIDTH is identity
    checks++;
    if (lat !== 1 || s !== 8'h47) begin
      errors++;
      $display("FAIL rol_full: got L=%0d s=%h want L=1 s=47", lat, s);
    end
  endtask

  task automatic test_mul_ovf();
    int lat;
    run_op(4'd8, 8'h20, 8'h10, lat);
    checks++;
    if (lat !== MUL_L || s !== 8'h00 || zero !== 1'b1 || carry !== 1'b1) begin
      errors++;
      $display("FAIL mul_ovf: got L=%0d s=%h z=%b c=%b want L=%0d s=00 z=1 c=1",
               lat, s, zero, carry, MUL_L);
    end
  endtask

  task automatic test_start_while_busy();
    int n = 0;
    int extra = 0;
    @(negedge clk);
    select = LONG_SEL; a = 8'h47; b = LONG_B; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; select = 4'd4; a = 8'hFF; b = 8'hFF;  // must not leak in
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 2) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_mid: got busy=%b want 1", busy);
        end
        start = 1'b1;
      end
      if (n == 3) start = 1'b0;
    end
    checks++;
    if (done !== 1'b1 || n !== LONG_L || s !== LONG_S || carry !== LONG_C) begin
      errors++;
      $display("FAIL ignore_start: got done=%b L=%0d s=%h c=%b want L=%0d s=%h c=%b",
               done, n, s, carry, LONG_L, LONG_S, LONG_C);
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL no_queued_start: got %0d busy/done cycles want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] sa [4] = '{8'h01, 8'hF0, 8'h7F, 8'hFF};
    logic [7:0] sb [4] = '{8'h02, 8'h20, 8'h01, 8'h01};
    logic [7:0] es [4] = '{8'h03, 8'h10, 8'h80, 8'h00};
    logic       ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    select = 4'd4; a = sa[0]; b = sb[0]; start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i > 0) begin
        checks++;
        if (done !== 1'b1 || s !== es[i-1] || carry !== ec[i-1]) begin
          errors++;
          $display("FAIL stream%0d: got done=%b s=%h c=%b want 1 %h %b",
                   i - 1, done, s, carry, es[i-1], ec[i-1]);
        end
      end
      @(negedge clk);
      if (i < 3) begin a = sa[i+1]; b = sb[i+1]; end
      else start = 1'b0;
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || s !== es[3] || zero !== 1'b1 || carry !== ec[3]) begin
      errors++;
      $display("FAIL stream3: got done=%b s=%h z=%b c=%b want 1 00 1 1", done, s, zero, carry);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stream_end: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_abort();
    int lat;
    int dones = 0;
    run_op(4'd4, 8'h7F, 8'h01, lat);  // leaves s=80, negative=1
    @(negedge clk);
    select = LONG_SEL; a = 8'h47; b = LONG_B; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({s, busy, done, zero, negative, carry, err} !== 14'h0) begin
      errors++;
      $display("FAIL abort_reset: got s=%h busy=%b done=%b z=%b n=%b c=%b e=%b, want all 0",
               s, busy, done, zero, negative, carry, err);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0) begin
      errors++;
      $display("FAIL abort_no_done: got %0d done pulses want 0", dones);
    end
  endtask

  task automatic test_invalid();
    int lat;
    run_op(4'd12, 8'h47, 8'h02, lat);
    checks++;
    if (lat !== 1 || s !== 8'h00 || err !== 1'b1 || zero !== 1'b1 || carry !== 1'b0) begin
      errors++;
      $display("FAIL invalid12: got L=%0d s=%h e=%b z=%b c=%b want L=1 s=00 e=1 z=1 c=0",
               lat, s, err, zero, carry);
    end
    run_op(4'd15, 8'h47, 8'h02, lat);
    checks++;
    if (lat !== 1 || err !== 1'b1) begin
      errors++;
      $display("FAIL invalid15: got L=%0d e=%b want L=1 e=1", lat, err);
    end
    run_op(4'd4, 8'h47, 8'h02, lat);
    checks++;
    if (lat !== 1 || s !== 8'h49 || err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got L=%0d s=%h e=%b want L=1 s=49 e=0", lat, s, err);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_sub();
    test_shift_edges();
    test_mul_ovf();
    test_start_while_busy();
    test_back_to_back();
    test_abort();
    test_invalid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
